// File: rtl/ast_mux_pkg.sv
// Shared widths, defaults and types for the Avalon-ST packet multiplexer.
package usr_types_and_params;

  function automatic int sel_width(input int n);
    return (n == 1) ? 1 : $clog2(n);
  endfunction

  localparam int DATA_WIDTH    = 64;
  localparam int CHANNEL_W     = 10;
  localparam int EMPTY_WIDTH   = $clog2(DATA_WIDTH / 8);
  localparam int RX_DIR        = 4;
  localparam int DIR_SEL_WIDTH = sel_width(RX_DIR);

  typedef logic [CHANNEL_W-1:0]     channel_t;
  typedef logic [EMPTY_WIDTH-1:0]   empty_t;
  typedef logic [DIR_SEL_WIDTH-1:0] dir_sel_t;

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } mux_state_e;

endpackage

// File: rtl/ast_mux_if.sv
// Avalon-ST bundle; LANES > 1 carries several parallel streams side by side.
interface ast_mux_if #(
  parameter int LANES       = 1,
  parameter int DATA_WIDTH  = 64,
  parameter int CHANNEL_W   = 10,
  parameter int EMPTY_WIDTH = 3
);
  logic [LANES-1:0][DATA_WIDTH-1:0]  data;
  logic [LANES-1:0]                  sop;
  logic [LANES-1:0]                  eop;
  logic [LANES-1:0]                  valid;
  logic [LANES-1:0][EMPTY_WIDTH-1:0] empty;
  logic [LANES-1:0][CHANNEL_W-1:0]   channel;
  logic [LANES-1:0]                  ready;

  modport master (output data, sop, eop, valid, empty, channel, input ready);
  modport slave  (input data, sop, eop, valid, empty, channel, output ready);
endinterface

// File: rtl/ast_mux_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last winner, pointer moves
// only when a grant is taken while enabled.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [N-1:0]     req_i,
  input  logic             en_i,
  output logic [SEL_W-1:0] grant_o,
  output logic             grant_valid_o
);

  logic [SEL_W-1:0] ptr_q;

  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
    grant_valid_o = 1'b0;
    grant_o       = '0;
    for (int i = 0; i < N; i++) begin
      if (!grant_valid_o && req_i[(int'(ptr_q) + i) % N]) begin
        grant_valid_o = 1'b1;
        grant_o       = SEL_W'((int'(ptr_q) + i) % N);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (srst_i) begin
      ptr_q <= '0;
    end else if (en_i && grant_valid_o) begin
      ptr_q <= (int'(grant_o) == N - 1) ? '0 : grant_o + 1'b1;
    end
  end

endmodule

// File: rtl/ast_mux.sv
// Packet-atomic N:1 Avalon-ST multiplexer with round-robin arbitration and a
// single registered output stage (latency 1, full throughput).
module ast_mux #(
  parameter int  DATA_WIDTH    = usr_types_and_params::DATA_WIDTH,
  parameter int  CHANNEL_W     = usr_types_and_params::CHANNEL_W,
  parameter int  EMPTY_WIDTH   = $clog2(DATA_WIDTH / 8),
  parameter int  RX_DIR        = usr_types_and_params::RX_DIR,
  localparam int DIR_SEL_WIDTH = usr_types_and_params::sel_width(RX_DIR)
) (
  input  logic                                  clk_i,
  input  logic                                  srst_i,
  input  logic [RX_DIR-1:0][DATA_WIDTH-1:0]     ast_data_i,
  input  logic [RX_DIR-1:0]                     ast_startofpacket_i,
  input  logic [RX_DIR-1:0]                     ast_endofpacket_i,
  input  logic [RX_DIR-1:0]                     ast_valid_i,
  input  logic [RX_DIR-1:0][EMPTY_WIDTH-1:0]    ast_empty_i,
  input  logic [RX_DIR-1:0][CHANNEL_W-1:0]      ast_channel_i,
  output logic [RX_DIR-1:0]                     ast_ready_o,
  output logic [DATA_WIDTH-1:0]                 ast_data_o,
  output logic                                  ast_startofpacket_o,
  output logic                                  ast_endofpacket_o,
  output logic                                  ast_valid_o,
  output logic [EMPTY_WIDTH-1:0]                ast_empty_o,
  output logic [CHANNEL_W-1:0]                  ast_channel_o,
  output logic [DIR_SEL_WIDTH-1:0]              dir_o,
  input  logic                                  ast_ready_i
);

  import usr_types_and_params::*;

  mux_state_e               state_q, state_d;
  logic [DIR_SEL_WIDTH-1:0] grant_q, grant_d, arb_grant;
  logic                     arb_valid;
  logic                     load;
  logic                     accept;
  logic [RX_DIR-1:0]        sop_req;

  // Only a beat carrying SOP may open a new packet.
  assign sop_req = ast_valid_i & ast_startofpacket_i;
  assign load    = !ast_valid_o || ast_ready_i;

  rr_arbiter #(
    .N     (RX_DIR),
    .SEL_W (DIR_SEL_WIDTH)
  ) u_rr_arbiter (
    .clk_i         (clk_i),
    .srst_i        (srst_i),
    .req_i         (sop_req),
    .en_i          (state_q == ST_IDLE),
    .grant_o       (arb_grant),
    .grant_valid_o (arb_valid)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ast_ready_o = '0;
    accept      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d = ST_LOCKED;
          grant_d = arb_grant;
        end
      end
      ST_LOCKED: begin
        ast_ready_o[grant_q] = load && !srst_i;
        accept               = ast_valid_i[grant_q] && load;
        if (accept && ast_endofpacket_i[grant_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      // NOTE: the output data path is reset too, so a partial packet leaves nothing visible behind.
      state_q             <= ST_IDLE;
      grant_q             <= '0;
      ast_valid_o         <= 1'b0;
      ast_data_o          <= '0;
      ast_startofpacket_o <= 1'b0;
      ast_endofpacket_o   <= 1'b0;
      ast_empty_o         <= '0;
      ast_channel_o       <= '0;
      dir_o               <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      if (load) ast_valid_o <= accept;
      if (accept) begin
        ast_data_o          <= ast_data_i[grant_q];
        ast_startofpacket_o <= ast_startofpacket_i[grant_q];
        ast_endofpacket_o   <= ast_endofpacket_i[grant_q];
        ast_empty_o         <= ast_empty_i[grant_q];
        ast_channel_o       <= ast_channel_i[grant_q];
        dir_o               <= grant_q;
      end
    end
  end

endmodule

// File: doc/ast_mux.md
AST_MUX -- requirements
Module: ast_mux

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, data bus width in bits (multiple of 8).
REQ-002 SHALL have parameter CHANNEL_W, default 10, channel field width.
REQ-003 SHALL have parameter EMPTY_WIDTH, default $clog2(DATA_WIDTH/8), empty field width.
REQ-004 SHALL have parameter RX_DIR, default 4, number of input streams; DIR_SEL_WIDTH = (RX_DIR==1) ? 1 : $clog2(RX_DIR).
REQ-005 SHALL have ports, one per line, in this order:
  clk_i  input  1  single clock; all logic on rising edge
  srst_i  input  1  reset, synchronous, active-high
  ast_data_i  input  RX_DIR x DATA_WIDTH  per-input data
  ast_startofpacket_i  input  RX_DIR  per-input SOP
  ast_endofpacket_i  input  RX_DIR  per-input EOP
  ast_valid_i  input  RX_DIR  per-input valid
  ast_empty_i  input  RX_DIR x EMPTY_WIDTH  per-input empty bytes, meaningful on EOP only
  ast_channel_i  input  RX_DIR x CHANNEL_W  per-input channel
  ast_ready_o  output  RX_DIR  per-input ready
  ast_data_o  output  DATA_WIDTH  merged data
  ast_startofpacket_o  output  1  merged SOP
  ast_endofpacket_o  output  1  merged EOP
  ast_valid_o  output  1  merged valid
  ast_empty_o  output  EMPTY_WIDTH  merged empty
  ast_channel_o  output  CHANNEL_W  merged channel
  dir_o  output  DIR_SEL_WIDTH  index of source input for current output beat
  ast_ready_i  input  1  downstream ready

Function
REQ-006 SHALL merge RX_DIR packet streams into one, packet-atomic: once granted, an input owns the output until its EOP beat is accepted.
REQ-007 SHALL implement FSM IDLE/LOCKED; IDLE -> LOCKED when any ast_valid_i[k] with SOP is high, grant registered to winner; LOCKED -> IDLE on acceptance of a beat with EOP from granted input.
REQ-008 SHALL arbitrate round-robin: search starts at (last_winner+1) mod RX_DIR; after reset search starts at 0.
REQ-009 SHALL ignore (hold ast_ready_o low for) valid beats without SOP from ungranted inputs in IDLE.
REQ-010 SHALL assert ast_ready_o[k] only in LOCKED, only for granted k, and only when output register can load (!ast_valid_o || ast_ready_i); all other ready bits 0.
REQ-011 SHALL register every output: beat accepted at input on cycle N appears on outputs at cycle N+1 (latency 1); full throughput of 1 beat/cycle while LOCKED and ast_ready_i high.
REQ-012 SHALL hold all output fields stable while ast_valid_o=1 and ast_ready_i=0.
REQ-013 SHALL drive dir_o with the granted index, stable for all beats of a packet.
REQ-014 SHALL pass ast_empty_i and ast_channel_i unchanged with the accepted beat.
REQ-015 SHALL, for single-beat packets (SOP and EOP same beat), return to IDLE after that beat; minimum gap between packets is one IDLE arbitration cycle.
REQ-016 SHALL, with RX_DIR=1, degenerate to a registered pass-through with the same FSM and dir_o=0.
REQ-017 SHALL not clear ast_valid_o on IDLE entry; last beat drains normally.

Reset
REQ-018 SHALL, while srst_i=1 at a clock edge, set FSM to IDLE, round-robin pointer to 0, ast_valid_o=0, ast_ready_o=0, ast_startofpacket_o=0, ast_endofpacket_o=0, ast_data_o=0, ast_empty_o=0, ast_channel_o=0, dir_o=0.
REQ-019 SHALL, on reset mid-packet, discard the partial packet; no EOP is synthesized.

Structure
REQ-020 SHALL place DATA_WIDTH, CHANNEL_W, EMPTY_WIDTH, RX_DIR, DIR_SEL_WIDTH defaults and typedefs channel_t, empty_t, dir_sel_t in the shared usr_types_and_params package.
REQ-021 SHALL implement arbitration in one sub-module rr_arbiter (request vector, enable, grant index, grant valid, pointer update).

Verification
REQ-022 Reset: srst_i high 2 cycles mid-stream -> all outputs 0 next cycle, FSM IDLE, pointer 0.
REQ-023 Single source: input 2 sends 10-beat packet, data 0..9, empty=3 on EOP, channel=5, ast_ready_i=1 -> output 0..9 one beat/cycle, 1-cycle latency, dir_o=2, empty=3, channel=5.
REQ-024 Contention: inputs 0,1,3 all assert SOP same cycle after reset -> packets emerge in order 0,1,3, each contiguous, no interleave.
REQ-025 Backpressure: ast_ready_i toggled 1,0,0,1 during 6-beat packet -> outputs held while ready=0, no beat lost or duplicated, ast_ready_o[k] low when output full.
REQ-026 Single-beat packets: inputs 0 and 1 each send 3 one-beat packets back to back -> alternating 0,1,0,1,0,1, dir_o matches.
REQ-027 Random: 10 runs, random lengths 1..1024, random valid/ready gaps -> scoreboard per-source packets byte-exact, empty and channel correct.
